axi_aw_arbiter_2x1: RTL

Two-master to one-slave arbiter for the AXI write-address (AW) channel of the interconnect: the merge direction that complements the 1-to-2 response demultiplexer. Round-robin grant, locked until the AW handshake completes, with the winner's payload and VALID forwarded to the slave port. Each granted master index is recorded in an in-order route FIFO. The FIFO head drives `b_select`, which steers the write-response demux until the matching B handshake retires it.

---
 rtl/axi_ic_pkg.sv | 14 +
 rtl/axi_route_fifo.sv | 61 ++++++
 rtl/axi_aw_arbiter_2x1.sv | 90 +++++++++
 3 files changed

// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect arbiters and routers.
// Holds state encodings, index widths and default geometry.
package axi_ic_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam int MIDX_W        = 1;
    localparam int DEF_PAYLOAD_W = 32;
    localparam int DEF_DEPTH     = 4;

endpackage

// File: rtl/axi_route_fifo.sv
// In-order route FIFO remembering which master owns each outstanding transaction.
// DEPTH must be a power of two so the pointers wrap naturally.
module axi_route_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign head  = mem[rptr];

    // A pop while empty is dropped; a push into a full FIFO is only legal alongside a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_aw_arbiter_2x1.sv
// Round-robin 2:1 AXI write-address arbiter; the grant holds until the AW handshake,
// and each winner is queued so the B demux can route responses back in order.
module axi_aw_arbiter_2x1
    import axi_ic_pkg::*;
#(
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [PAYLOAD_W-1:0] m0_aw_payload,
    input  logic                 m0_awvalid,
    output logic                 m0_awready,
    input  logic [PAYLOAD_W-1:0] m1_aw_payload,
    input  logic                 m1_awvalid,
    output logic                 m1_awready,
    output logic [PAYLOAD_W-1:0] s_aw_payload,
    output logic                 s_awvalid,
    input  logic                 s_awready,
    input  logic                 s_bvalid,
    input  logic                 s_bready,
    output logic                 b_select,
    output logic                 b_route_valid,
    output logic                 route_full
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    arb_state_e        state;
    logic [MIDX_W-1:0] grant;
    logic [MIDX_W-1:0] prio;
    logic              locked;
    logic              aw_hs;
    logic [MIDX_W-1:0] route_head;
    logic              route_empty;
    logic [CNT_W-1:0]  route_count;

    assign locked = (state == ST_LOCKED);

    // Slave side mirrors the granted master only while locked; everything is quiet in IDLE.
    assign s_awvalid    = locked && (grant[0] ? m1_awvalid : m0_awvalid);
    assign s_aw_payload = locked ? (grant[0] ? m1_aw_payload : m0_aw_payload) : '0;
    assign m0_awready   = locked && !grant[0] && s_awready;
    assign m1_awready   = locked &&  grant[0] && s_awready;
    assign aw_hs        = s_awvalid && s_awready;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= ST_IDLE;
            grant <= '0;
            prio  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // No new grant while every route slot is taken.
                    if ((m0_awvalid || m1_awvalid) && (route_count < CNT_W'(DEPTH))) begin
                        state <= ST_LOCKED;
                        grant <= (m0_awvalid && m1_awvalid) ? prio : m1_awvalid;
                    end
                end
                ST_LOCKED: begin
                    if (aw_hs) begin
                        state <= ST_IDLE;
                        prio  <= ~grant;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    axi_route_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MIDX_W)
    ) u_route_fifo (
        .clk   (ACLK),
        .reset (ARESET),
        .push  (aw_hs),
        .pop   (s_bvalid && s_bready),
        .din   (grant),
        .head  (route_head),
        .empty (route_empty),
        .full  (route_full),
        .count (route_count)
    );

    assign b_route_valid = !route_empty;
    assign b_select      = route_empty ? 1'b0 : route_head[0];

endmodule
